// File: rtl/hack_arb_mux.sv
// N:1 arbitrated word mux (round-robin or fixed priority) into a single registered output stage; 1-cycle latency.
// Backpressure: while out_valid & !out_ready the held word is stable and every in_ready is 0.
module hack_arb_mux #(
   parameter int WIDTH    = 16,
   parameter int CHANNELS = 4,
   parameter int ARB_MODE = 0,
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [CHANNELS*WIDTH-1:0]   in_data,
   input  logic [CHANNELS-1:0]         in_valid,
   output logic [CHANNELS-1:0]         in_ready,
   input  logic                        lock,
   output logic [WIDTH-1:0]            out_data,
   output logic [CW-1:0]               out_chan,
   output logic                        out_valid,
   input  logic                        out_ready
);

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [CW-1:0]    out_chan_q, out_chan_d;
   logic             out_valid_q, out_valid_d;
   logic [CW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]    owner_q, owner_d;
   logic             owner_vld_q, owner_vld_d;

   logic             stage_free;
   logic             gnt_vld;
   logic [CW-1:0]    gnt_idx;

   assign stage_free = !out_valid_q || out_ready;

   always_comb begin
      int idx;
      gnt_vld  = 1'b0;
      gnt_idx  = '0;
      in_ready = '0;
      idx      = 0;
      if (lock && owner_vld_q) begin
         // Burst: only the owner may transfer; others stall even if the owner is idle.
         gnt_vld = in_valid[owner_q];
         gnt_idx = owner_q;
      end else if (ARB_MODE == 1) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (!gnt_vld && in_valid[i]) begin
               gnt_vld = 1'b1;
               gnt_idx = CW'(i);
            end
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= CHANNELS) idx = idx - CHANNELS;
            if (!gnt_vld && in_valid[idx]) begin
               gnt_vld = 1'b1;
               gnt_idx = CW'(idx);
            end
         end
      end
      if (reset || !stage_free) gnt_vld = 1'b0;
      if (gnt_vld) in_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q && !out_ready;
      rr_ptr_d    = rr_ptr_q;
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q && lock;
      if (gnt_vld) begin
         out_data_d  = in_data[int'(gnt_idx)*WIDTH +: WIDTH];
         out_chan_d  = gnt_idx;
         out_valid_d = 1'b1;
         // The last accepted channel becomes the owner so a following lock cycle keeps it.
         owner_d     = gnt_idx;
         owner_vld_d = 1'b1;
         if (int'(gnt_idx) == CHANNELS - 1) rr_ptr_d = '0;
         else                               rr_ptr_d = gnt_idx + CW'(1);
      end
      if (ARB_MODE == 1) rr_ptr_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         owner_vld_q <= 1'b0;
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         rr_ptr_q    <= rr_ptr_d;
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;

endmodule
